// File: rtl/div_pkg.sv
// div_pkg: shared state enum, request struct and default widths for the sequential divider
package div_pkg;
  localparam int DEF_DIVIDEND_W = 32;
  localparam int DEF_DIVISOR_W = 32;
  localparam int DEF_FRAC_BITS = 32;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef struct packed {
    logic [DEF_DIVIDEND_W-1:0] a;
    logic [DEF_DIVISOR_W-1:0] b;
    logic recip;
    logic op_signed;
  } req_t;
endpackage

// File: rtl/sequential_divider_if.sv
// sequential_divider_if: divider request/result handshake bus; master issues operands and takes results, slave is the divider
interface sequential_divider_if
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W = DEF_DIVISOR_W,
  parameter int FRAC_BITS = DEF_FRAC_BITS
);
  localparam int QUOT_W = DIVIDEND_W + FRAC_BITS;
  logic in_valid;
  logic in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0] divisor;
  logic recip;
  logic op_signed;
  logic out_valid;
  logic out_ready;
  logic [QUOT_W-1:0] quotient;
  logic [DIVISOR_W-1:0] remainder;
  logic dvz;
  logic ovf;
  modport master (
    output in_valid, dividend, divisor, recip, op_signed, out_ready,
    input in_ready, out_valid, quotient, remainder, dvz, ovf
  );
  modport slave (
    input in_valid, dividend, divisor, recip, op_signed, out_ready,
    output in_ready, out_valid, quotient, remainder, dvz, ovf
  );
endinterface

// File: rtl/div_step.sv
// div_step: one restoring iteration; ports pr_i/bit_i/b_i (partial remainder, next dividend bit, divisor) -> pr_o/q_o
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   pr_i,
  input  logic         bit_i,
  input  logic [W-1:0] b_i,
  output logic [W:0]   pr_o,
  output logic         q_o
);
  logic [W+1:0] sh;
  assign sh = {pr_i, bit_i};
  assign q_o = sh >= {2'b00, b_i};
  assign pr_o = q_o ? (W+1)'(sh - {2'b00, b_i}) : sh[W:0];
endmodule

// File: rtl/sequential_divider.sv
// sequential_divider: restoring divider Q=floor(A*2^FRAC_BITS/B) one bit per clk; ports clk, rst_n, bus (slave: in/out valid-ready, dividend, divisor, recip, op_signed, quotient, remainder, dvz, ovf)
module sequential_divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W = DEF_DIVISOR_W,
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input logic clk,
  input logic rst_n,
  sequential_divider_if.slave bus
);
  localparam int QUOT_W = DIVIDEND_W + FRAC_BITS;
  localparam int CNT_W = $clog2(QUOT_W + 1);
  localparam logic [QUOT_W-1:0] HALF = {1'b1, {(QUOT_W-1){1'b0}}};
  state_t state_q;
  logic in_ready_q, out_valid_q, dvz_q, ovf_q, a_neg_q, b_neg_q, sgn_q;
  logic [QUOT_W-1:0] quotient_q, sh_q, qm_d, q_fix_d;
  logic [DIVISOR_W-1:0] remainder_q, b_q, rm_d, r_fix_d, b_abs_d, a_low_d;
  logic [DIVISOR_W:0] pr_q, pr_d;
  logic [DIVIDEND_W-1:0] a_abs_d;
  logic [CNT_W-1:0] cnt_q;
  logic a_neg_d, b_neg_d, q_bit_d, neg_q_d, ovf_d;
  assign a_neg_d = bus.op_signed && !bus.recip && bus.dividend[DIVIDEND_W-1];
  assign b_neg_d = bus.op_signed && bus.divisor[DIVISOR_W-1];
  assign a_abs_d = bus.recip ? DIVIDEND_W'(1) : a_neg_d ? -bus.dividend : bus.dividend;
  assign b_abs_d = b_neg_d ? -bus.divisor : bus.divisor;
  assign a_low_d = bus.recip ? DIVISOR_W'(1) : DIVISOR_W'(bus.dividend);
  div_step #(.W(DIVISOR_W)) u_step (
    .pr_i (pr_q),
    .bit_i(sh_q[QUOT_W-1]),
    .b_i  (b_q),
    .pr_o (pr_d),
    .q_o  (q_bit_d)
  );
  // sh_q streams dividend bits out of the top while quotient bits enter at the bottom
  assign qm_d = {sh_q[QUOT_W-2:0], q_bit_d};
  assign rm_d = DIVISOR_W'(pr_d);
  assign neg_q_d = a_neg_q ^ b_neg_q;
  // magnitude 2^(QUOT_W-1) is representable only as a negative result
  assign ovf_d = sgn_q && (neg_q_d ? qm_d > HALF : qm_d >= HALF);
  assign q_fix_d = ovf_d ? (neg_q_d ? HALF : ~HALF) : neg_q_d ? -qm_d : qm_d;
  assign r_fix_d = a_neg_q ? -rm_d : rm_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q <= '0;
      remainder_q <= '0;
      dvz_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      pr_q <= '0;
      sh_q <= '0;
      b_q <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      sgn_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          a_neg_q <= a_neg_d;
          b_neg_q <= b_neg_d;
          sgn_q <= bus.op_signed;
          b_q <= b_abs_d;
          in_ready_q <= 1'b0;
          if (b_abs_d == '0) begin
            state_q <= DONE;
            out_valid_q <= 1'b1;
            dvz_q <= 1'b1;
            ovf_q <= 1'b0;
            quotient_q <= '1;
            remainder_q <= a_low_d;
          end else begin
            state_q <= CALC;
            cnt_q <= '0;
            pr_q <= '0;
            sh_q <= QUOT_W'(a_abs_d) << FRAC_BITS;
          end
        end
        CALC: begin
          pr_q <= pr_d;
          sh_q <= qm_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(QUOT_W - 1)) begin
            state_q <= DONE;
            out_valid_q <= 1'b1;
            quotient_q <= q_fix_d;
            remainder_q <= r_fix_d;
            dvz_q <= 1'b0;
            ovf_q <= ovf_d;
          end
        end
        DONE: if (bus.out_ready) begin
          state_q <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quotient = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.dvz = dvz_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_sequential_divider.sv
// tb_sequential_divider: table-driven scoreboard bench for sequential_divider at default widths
module tb_sequential_divider;
  import div_pkg::*;
  typedef struct {
    req_t req;
    logic [63:0] q;
    logic [31:0] r;
    logic dvz;
    logic ovf;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_err = 0;
  int n_chk = 0;
  vec_t sb[$];
  vec_t vt[14];
  sequential_divider_if bus();
  sequential_divider dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic [31:0] a, b, input logic rc, sg,
                              input logic [63:0] q, input logic [31:0] r, input logic dz, ov);
    vec_t v;
    v.req.a = a;
    v.req.b = b;
    v.req.recip = rc;
    v.req.op_signed = sg;
    v.q = q;
    v.r = r;
    v.dvz = dz;
    v.ovf = ov;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input req_t rq);
    bus.dividend = rq.a;
    bus.divisor = rq.b;
    bus.recip = rq.recip;
    bus.op_signed = rq.op_signed;
  endtask
  task automatic send(input vec_t v, input string nm);
    int t = 0;
    drive(v.req);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 300) begin
      cyc();
      t++;
    end
    chk({nm, " in_ready"}, 64'(bus.in_ready), 64'd1);
    cyc();
    bus.in_valid = 1'b0;
    sb.push_back(v);
  endtask
  task automatic cmp(input string nm);
    vec_t e;
    chk({nm, " pending"}, 64'(sb.size()), 64'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({nm, " out_valid"}, 64'(bus.out_valid), 64'd1);
    chk({nm, " quotient"}, bus.quotient, e.q);
    chk({nm, " remainder"}, 64'(bus.remainder), 64'(e.r));
    chk({nm, " dvz"}, 64'(bus.dvz), 64'(e.dvz));
    chk({nm, " ovf"}, 64'(bus.ovf), 64'(e.ovf));
  endtask
  task automatic collect(input string nm, input int lat);
    int t = 0;
    while (!bus.out_valid && t < 300) begin
      cyc();
      t++;
    end
    chk({nm, " latency"}, 64'(t), 64'(lat));
    cmp(nm);
    cyc();
    chk({nm, " out_valid drop"}, 64'(bus.out_valid), 64'd0);
  endtask
  initial begin
    int t;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.dividend = '0;
    bus.divisor = '0;
    bus.recip = 1'b0;
    bus.op_signed = 1'b0;
    cyc();
    cyc();
    chk("reset in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset quotient", bus.quotient, 64'd0);
    chk("reset remainder", 64'(bus.remainder), 64'd0);
    chk("reset dvz", 64'(bus.dvz), 64'd0);
    chk("reset ovf", 64'(bus.ovf), 64'd0);
    #3 rst_n = 1'b1;
    cyc();
    vt[0]  = mk(32'h0, 32'h13, 1, 0, 64'h0000_0000_0D79_435E, 32'd6, 0, 0);
    vt[1]  = mk(32'd7, 32'd2, 0, 0, 64'h0000_0003_8000_0000, 32'd0, 0, 0);
    vt[2]  = mk(32'hFFFF_FFF9, 32'd2, 0, 1, 64'hFFFF_FFFC_8000_0000, 32'd0, 0, 0);
    vt[3]  = mk(32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 32'd0, 0, 1);
    vt[4]  = mk(32'd5, 32'd0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 32'd5, 1, 0);
    vt[5]  = mk(32'd1, 32'd3, 0, 0, 64'h0000_0000_5555_5555, 32'd1, 0, 0);
    vt[6]  = mk(32'hFFFF_FFFF, 32'd1, 0, 0, 64'hFFFF_FFFF_0000_0000, 32'd0, 0, 0);
    vt[7]  = mk(32'hFFFF_FFFF, 32'h8000_0000, 0, 1, 64'h0000_0000_0000_0002, 32'd0, 0, 0);
    vt[8]  = mk(32'hFFFF_FFF9, 32'd3, 0, 1, 64'hFFFF_FFFD_AAAA_AAAB, 32'hFFFF_FFFF, 0, 0);
    vt[9]  = mk(32'h8000_0000, 32'hFFFF_FFFC, 1, 1, 64'hFFFF_FFFF_C000_0000, 32'd0, 0, 0);
    vt[10] = mk(32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 64'h0000_0000_8000_0000, 32'h8000_0000, 0, 0);
    vt[11] = mk(32'h8000_0000, 32'd1, 0, 1, 64'h8000_0000_0000_0000, 32'd0, 0, 0);
    vt[12] = mk(32'h1234, 32'd0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 1, 0);
    vt[13] = mk(32'hFFFF_FFFB, 32'd0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFB, 1, 0);
    for (int i = 0; i < 14; i++) begin
      send(vt[i], $sformatf("vec%0d", i));
      collect($sformatf("vec%0d", i), vt[i].dvz ? 0 : 64);
    end
    bus.out_ready = 1'b0;
    send(vt[1], "bp");
    t = 0;
    while (!bus.out_valid && t < 300) begin
      cyc();
      t++;
    end
    chk("bp latency", 64'(t), 64'd64);
    drive(vt[5].req);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk($sformatf("bp hold q %0d", k), bus.quotient, 64'h0000_0003_8000_0000);
      chk($sformatf("bp hold valid %0d", k), 64'(bus.out_valid), 64'd1);
      chk($sformatf("bp in_ready %0d", k), 64'(bus.in_ready), 64'd0);
    end
    cmp("bp");
    bus.out_ready = 1'b1;
    cyc();
    chk("bp after handshake out_valid", 64'(bus.out_valid), 64'd0);
    chk("bp after handshake in_ready", 64'(bus.in_ready), 64'd1);
    cyc();
    chk("bp second accepted", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;
    sb.push_back(vt[5]);
    collect("bp second", 64);
    drive(vt[1].req);
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    chk("rst calc in_ready", 64'(bus.in_ready), 64'd0);
    repeat (10) cyc();
    #3 rst_n = 1'b0;
    #1;
    chk("rst async in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst async out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst async quotient", bus.quotient, 64'd0);
    cyc();
    #3 rst_n = 1'b1;
    cyc();
    chk("rst no result", 64'(bus.out_valid), 64'd0);
    send(vt[5], "rst 1/3");
    collect("rst 1/3", 64);
    chk("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
